// File: rtl/axil_gpio_pkg.sv
// Shared constants, types and the address decoder for the AXI4-Lite GPIO block.
package axil_gpio_pkg;

  localparam int unsigned BANK_WIDTH = 32;

  // Register region bases, expressed as byte offsets in the 4 KB window
  localparam logic [11:0] OUT_BASE = 12'h000;
  localparam logic [11:0] DIR_BASE = 12'h100;
  localparam logic [11:0] IN_BASE  = 12'h200;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RegOut, RegDir, RegIn, RegNone} reg_sel_e;

  typedef struct packed {
    reg_sel_e    sel;
    logic [5:0]  bank;
  } reg_dec_t;

  // Decode a word address (offset[11:2]) into a register kind and bank index.
  // Offsets whose bank index is beyond the implemented banks decode to RegNone.
  function automatic reg_dec_t decode_addr(logic [9:0] word, int unsigned nbank);
    reg_dec_t d;
    d.bank = word[5:0];
    d.sel  = RegNone;
    if (32'(word[5:0]) < nbank) begin
      if (word[9:6] == OUT_BASE[11:8]) begin
        d.sel = RegOut;
      end else if (word[9:6] == DIR_BASE[11:8]) begin
        d.sel = RegDir;
      end else if (word[9:6] == IN_BASE[11:8]) begin
        d.sel = RegIn;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/axil_gpio_if.sv
// AXI4-Lite bus bundle with master/slave views.
interface axil_gpio_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gpio_bank.sv
// One GPIO bank: OUT/DIR registers with byte strobes, tri-state pad drivers
// and input sampling. Define AXIL_GPIO_INSYNC_EN for a 2-flop input synchronizer.
module gpio_bank
  import axil_gpio_pkg::*;
#(
  parameter int unsigned WIDTH = BANK_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    out_we,
  input  logic                    dir_we,
  input  logic [BANK_WIDTH-1:0]   wdata,
  input  logic [BANK_WIDTH/8-1:0] wstrb,
  output logic [BANK_WIDTH-1:0]   out_rd,
  output logic [BANK_WIDTH-1:0]   dir_rd,
  output logic [BANK_WIDTH-1:0]   in_rd,
  inout  wire  [WIDTH-1:0]        pad
);

  logic [BANK_WIDTH-1:0] bmask;
  logic [WIDTH-1:0]      wmask;
  logic [WIDTH-1:0]      out_q, dir_q, in_q;

  // Expand byte strobes into a bit mask clipped to the implemented pins
  always_comb begin
    for (int i = 0; i < BANK_WIDTH / 8; i++) begin
      bmask[8*i +: 8] = {8{wstrb[i]}};
    end
  end
  assign wmask = bmask[WIDTH-1:0];

  // OUT/DIR registers, merged byte-wise with existing contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      if (out_we) out_q <= (out_q & ~wmask) | (wdata[WIDTH-1:0] & wmask);
      if (dir_we) dir_q <= (dir_q & ~wmask) | (wdata[WIDTH-1:0] & wmask);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pad
    assign pad[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

`ifdef AXIL_GPIO_INSYNC_EN
  logic [WIDTH-1:0] sync_q;

  // Two-flop synchronizer on the pad inputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      in_q   <= '0;
    end else begin
      sync_q <= pad;
      in_q   <= sync_q;
    end
  end
`else
  // Single sampling stage on the pad inputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_q <= '0;
    end else begin
      in_q <= pad;
    end
  end
`endif

  assign out_rd = BANK_WIDTH'(out_q);
  assign dir_rd = BANK_WIDTH'(dir_q);
  assign in_rd  = BANK_WIDTH'(in_q);

endmodule

// File: rtl/axil_gpio_port.sv
// AXI4-Lite GPIO slave: NBANK banks of OUT/DIR/IN registers driving tri-state pads.
// Input synchronizer depth is selected by AXIL_GPIO_INSYNC_EN (see gpio_bank).
module axil_gpio_port
  import axil_gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned N_GPIO     = 64
) (
  input  logic              clk,
  input  logic              rstn,
  axil_gpio_if.slave        s_axil,
  inout  wire  [N_GPIO-1:0] gpio
);

  localparam int unsigned NBANK = (N_GPIO + BANK_WIDTH - 1) / BANK_WIDTH;

  logic                  wr_fire, rd_fire;
  reg_dec_t              wr_dec, rd_dec;
  logic [1:0]            wr_resp, rd_resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [NBANK-1:0]      out_we, dir_we;
  logic [BANK_WIDTH-1:0] out_rd [NBANK];
  logic [BANK_WIDTH-1:0] dir_rd [NBANK];
  logic [BANK_WIDTH-1:0] in_rd  [NBANK];

  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic unused_bits;
  assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[1:0], s_axil.araddr[1:0]};

  // A write needs both AW and W together and a free response slot
  assign wr_fire = s_axil.awvalid & s_axil.wvalid & ~bvalid_q;
  assign rd_fire = s_axil.arvalid & ~rvalid_q;
  assign wr_dec  = decode_addr(s_axil.awaddr[11:2], NBANK);
  assign rd_dec  = decode_addr(s_axil.araddr[11:2], NBANK);
  assign wstrb   = s_axil.wstrb;

  // Write decode: IN writes are accepted silently, unmapped ones flag SLVERR
  always_comb begin
    out_we  = '0;
    dir_we  = '0;
    wr_resp = (wr_dec.sel == RegNone) ? RESP_SLVERR : RESP_OKAY;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (wr_fire && wr_dec.bank == 6'(b)) begin
        out_we[b] = (wr_dec.sel == RegOut);
        dir_we[b] = (wr_dec.sel == RegDir);
      end
    end
  end

  // Read mux across banks; unmapped reads return zero
  always_comb begin
    rd_data = '0;
    rd_resp = (rd_dec.sel == RegNone) ? RESP_SLVERR : RESP_OKAY;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (rd_dec.bank == 6'(b)) begin
        case (rd_dec.sel)
          RegOut:  rd_data = out_rd[b];
          RegDir:  rd_data = dir_rd[b];
          RegIn:   rd_data = in_rd[b];
          default: ;
        endcase
      end
    end
  end

  // Write response channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_fire) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else if (s_axil.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read data channel; rdata holds until the beat is taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_data;
    end else if (s_axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil.awready = wr_fire;
  assign s_axil.wready  = wr_fire;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = rd_fire;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  for (genvar b = 0; b < int'(NBANK); b++) begin : g_bank
    // The last bank only owns the pins that exist
    localparam int unsigned W = (b == int'(NBANK) - 1) ?
                                (N_GPIO - BANK_WIDTH * b) : BANK_WIDTH;
    gpio_bank #(
      .WIDTH(W)
    ) u_bank (
      .clk    (clk),
      .rstn   (rstn),
      .out_we (out_we[b]),
      .dir_we (dir_we[b]),
      .wdata  (s_axil.wdata),
      .wstrb  (wstrb),
      .out_rd (out_rd[b]),
      .dir_rd (dir_rd[b]),
      .in_rd  (in_rd[b]),
      .pad    (gpio[BANK_WIDTH*b +: W])
    );
  end

endmodule

// File: tb/tb_axil_gpio_port.sv
// Directed bench for axil_gpio_port: register access, strobes, handshakes,
// error responses, input latency and asynchronous reset.
module tb_axil_gpio_port;
  import axil_gpio_pkg::*;

`ifdef AXIL_GPIO_INSYNC_EN
  localparam int IN_LAT = 2;
`else
  localparam int IN_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [63:0] pad_en  = '1;
  logic [63:0] pad_val = '0;
  wire  [63:0] gpio;

  int n_assert = 0;
  int n_fail   = 0;

  axil_gpio_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axil_gpio_port #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .N_GPIO     (64)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_axil (bus),
    .gpio   (gpio)
  );

  for (genvar i = 0; i < 64; i++) begin : g_ext
    assign gpio[i] = pad_en[i] ? pad_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write; returns at posedge+1 after the response beat is taken
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(bus.awready && bus.wready) && n < 50);
    chk("wr_accept", {62'b0, bus.awready, bus.wready}, 64'd3);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("wr_bvalid", {63'b0, bus.bvalid}, 64'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // Full read; returns at posedge+1 after the data beat is taken
  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.arready && n < 50);
    chk("rd_accept", {63'b0, bus.arready}, 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("rd_rvalid", {63'b0, bus.rvalid}, 64'd1);
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, ws;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {60'b0, bus.awready, bus.wready, bus.arready, 1'b0}, 64'd0);
    chk("rst_valid", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
    chk("rst_rdata", {32'b0, bus.rdata}, 64'd0);
    chk("rst_resp", {60'b0, bus.bresp, bus.rresp}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Post-reset reads with pads pulled to 0
    axi_read(12'h100, rd, rs);
    chk("dir0_rst", {30'b0, rs, rd}, 64'h0);
    axi_read(12'h004, rd, rs);
    chk("out1_rst", {30'b0, rs, rd}, 64'h0);
    axi_read(12'h200, rd, rs);
    chk("in0_zero", {30'b0, rs, rd}, 64'h0);

    // Pads are not driven by the DUT: an external pattern reads back intact
    pad_val = 64'h1234_5678_9ABC_DEF0;
    repeat (4) @(posedge clk); #1;
    axi_read(12'h200, rd, rs);
    chk("in0_hiz", {32'b0, rd}, 64'h9ABC_DEF0);
    axi_read(12'h204, rd, rs);
    chk("in1_hiz", {32'b0, rd}, 64'h1234_5678);
    pad_val = '0;

    // Low byte becomes output, the rest stay inputs driven low externally
    pad_en = ~64'hFF;
    axi_write(12'h100, 32'h0000_00FF, 4'hF, ws);
    chk("dir0_bresp", {62'b0, ws}, {62'b0, RESP_OKAY});
    axi_write(12'h000, 32'hA5A5_A5A5, 4'hF, ws);
    chk("out0_bresp", {62'b0, ws}, {62'b0, RESP_OKAY});
    @(negedge clk);
    chk("gpio_lo", {56'b0, gpio[7:0]}, 64'hA5);
    @(posedge clk); #1;
    axi_read(12'h200, rd, rs);
    chk("in0_loop", {30'b0, rs, rd}, 64'h0000_00A5);
    axi_read(12'h000, rd, rs);
    chk("out0_rd", {32'b0, rd}, 64'hA5A5_A5A5);

    // Single-byte strobe
    axi_write(12'h004, 32'hFFFF_FFFF, 4'b0010, ws);
    axi_read(12'h004, rd, rs);
    chk("out1_strb", {30'b0, rs, rd}, 64'h0000_FF00);

    // AW alone is held off until W arrives
    bus.awaddr = 12'h004; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_alone", {62'b0, bus.awready, bus.wready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_pulse", {62'b0, bus.awready, bus.wready}, 64'd3);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("ready_drop", {62'b0, bus.awready, bus.wready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bvalid_hold", {61'b0, bus.bvalid, bus.bresp}, 64'h4);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("bvalid_clr", {63'b0, bus.bvalid}, 64'd0);
    @(posedge clk); #1;
    axi_read(12'h004, rd, rs);
    chk("out1_held", {32'b0, rd}, 64'h1234_5678);

    // Unmapped and read-only accesses
    axi_read(12'h300, rd, rs);
    chk("rd_unmap", {30'b0, rs, rd}, {30'b0, RESP_SLVERR, 32'h0});
    axi_read(12'h008, rd, rs);
    chk("rd_nobank", {30'b0, rs, rd}, {30'b0, RESP_SLVERR, 32'h0});
    axi_write(12'h080, 32'hFFFF_FFFF, 4'hF, ws);
    chk("wr_unmap", {62'b0, ws}, {62'b0, RESP_SLVERR});
    axi_write(12'h200, 32'hFFFF_FFFF, 4'hF, ws);
    chk("wr_in_okay", {62'b0, ws}, {62'b0, RESP_OKAY});
    axi_read(12'h000, rd, rs);
    chk("out0_kept", {32'b0, rd}, 64'hA5A5_A5A5);
    axi_read(12'h004, rd, rs);
    chk("out1_kept", {32'b0, rd}, 64'h1234_5678);
    axi_read(12'h100, rd, rs);
    chk("dir0_kept", {32'b0, rd}, 64'h0000_00FF);
    axi_read(12'h200, rd, rs);
    chk("in0_kept", {32'b0, rd}, 64'h0000_00A5);

    // Pad-to-IN latency: one edge too early still reads 0
    repeat (4) @(posedge clk); #1;
    pad_val[40] = 1'b1;
    repeat (IN_LAT - 1) @(posedge clk);
    #1;
    axi_read(12'h204, rd, rs);
    chk("in1_early", {32'b0, rd}, 64'h0);
    pad_val[40] = 1'b0;
    repeat (4) @(posedge clk); #1;
    pad_val[40] = 1'b1;
    repeat (IN_LAT) @(posedge clk);
    #1;
    axi_read(12'h204, rd, rs);
    chk("in1_bit8", {32'b0, rd}, 64'h0000_0100);

    // Reset while a read response is pending
    bus.araddr = 12'h000; bus.arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("rv_pending", {63'b0, bus.rvalid}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("rv_drop", {63'b0, bus.rvalid}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    axi_read(12'h000, rd, rs);
    chk("out0_after_rst", {30'b0, rs, rd}, 64'h0);
    axi_read(12'h100, rd, rs);
    chk("dir0_after_rst", {30'b0, rs, rd}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
